// File: rtl/servo_pkg.sv
// servo_pkg: constants, decoder state enum and width-to-value conversion
// shared by the servo pulse generator and decoder.
package servo_pkg;

    localparam int TICK_DIV       = 16;
    localparam int PERIOD_CNT     = 23040;
    localparam int PULSE_1MS_CNT  = 1152;
    localparam int PULSE_15MS_CNT = 1728;
    localparam int VALUE_W        = 8;
    localparam int WIDTH_W        = 12;
    localparam int TIMEOUT_W      = 17;

    localparam logic [VALUE_W-1:0] VALUE_RESET = VALUE_W'((PULSE_15MS_CNT - PULSE_1MS_CNT) / 8);

    typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_MEASURE} dec_state_e;

    // Adding 4 before dropping three bits rounds to the nearest 8-tick step.
    function automatic logic [VALUE_W-1:0] width_to_value(input logic [WIDTH_W-1:0] width,
                                                          input int one_ms);
        logic signed [WIDTH_W:0] d;
        d = $signed({1'b0, width} - (WIDTH_W + 1)'(one_ms - 4));
        return d < 0 ? '0 : d >= 2048 ? '1 : d[10:3];
    endfunction

endpackage

// File: rtl/servo_pulse_channel_decoder.sv
// servo_pulse_channel_decoder: one channel of pulse-width measurement, from the
// raw pin through synchronizer, tick-sampled FSM, evaluation and timeout.
module servo_pulse_channel_decoder
    import servo_pkg::*;
#(
    parameter int PULSE_1MS_CNT = servo_pkg::PULSE_1MS_CNT,
    parameter int MIN_PULSE_CNT = 576,
    parameter int MAX_PULSE_CNT = 4095,
    parameter int TIMEOUT_CNT   = 69120
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               tick_i,
    input  logic               pulse_i,
    output logic [VALUE_W-1:0] value_o,
    output logic               valid_o,
    output logic               sample_o
);

    localparam logic [WIDTH_W-1:0]   MIN_W   = WIDTH_W'(MIN_PULSE_CNT);
    localparam logic [WIDTH_W-1:0]   LAST_W  = WIDTH_W'(MAX_PULSE_CNT - 1);
    localparam logic [TIMEOUT_W-1:0] TO_FULL = TIMEOUT_W'(TIMEOUT_CNT);

    logic                 sync1_q, sync2_q;
    dec_state_e           state_q, state_d;
    logic [WIDTH_W-1:0]   width_q, width_d;
    logic [TIMEOUT_W-1:0] to_q, to_d;
    logic [VALUE_W-1:0]   value_q, value_d;
    logic                 valid_q, valid_d;
    logic                 sample_q, sample_d;
    logic                 accept;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= ST_ARM;
            width_q  <= '0;
            to_q     <= '0;
            value_q  <= VALUE_RESET;
            valid_q  <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            sync1_q  <= pulse_i;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            width_q  <= width_d;
            to_q     <= to_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            sample_q <= sample_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick_i) begin
            case (state_q)
                ST_ARM:     state_d = sync2_q ? ST_ARM : ST_IDLE;
                ST_IDLE:    state_d = sync2_q ? ST_MEASURE : ST_IDLE;
                ST_MEASURE: state_d = !sync2_q ? ST_IDLE : width_q == LAST_W ? ST_ARM : ST_MEASURE;
                default:    state_d = ST_ARM;
            endcase
        end
    end

    // Acceptance outranks a timeout landing on the same tick.
    always_comb begin
        accept   = tick_i && state_q == ST_MEASURE && !sync2_q && width_q >= MIN_W;
        width_d  = !tick_i || !sync2_q ? width_q :
                   state_q == ST_IDLE ? WIDTH_W'(1) :
                   state_q == ST_MEASURE ? width_q + 1'b1 : width_q;
        value_d  = accept ? width_to_value(width_q, PULSE_1MS_CNT) : value_q;
        to_d     = !tick_i ? to_q : accept ? '0 : to_q == TO_FULL ? to_q : to_q + 1'b1;
        valid_d  = accept || (valid_q && to_d != TO_FULL);
        sample_d = accept;
    end

    assign value_o  = value_q;
    assign valid_o  = valid_q;
    assign sample_o = sample_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder: two-channel servo pulse-width decoder; shares one tick
// divider between the channels and packs their results.
module servo_pulse_decoder
    import servo_pkg::*;
#(
    parameter int TICK_DIV      = servo_pkg::TICK_DIV,
    parameter int PULSE_1MS_CNT = servo_pkg::PULSE_1MS_CNT,
    parameter int MIN_PULSE_CNT = 576,
    parameter int MAX_PULSE_CNT = 4095,
    parameter int TIMEOUT_CNT   = 69120
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [1:0]             servo_pulse_i,
    output logic [2*VALUE_W-1:0]   servo_control_value_o,
    output logic [1:0]             servo_valid_o,
    output logic [1:0]             servo_sample_o
);

    logic [3:0] div_q, div_d;
    logic       tick;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) div_q <= '0;
        else         div_q <= div_d;
    end

    always_comb begin
        tick  = div_q == 4'(TICK_DIV - 1);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    for (genvar i = 0; i < 2; i++) begin : g_ch
        servo_pulse_channel_decoder #(
            .PULSE_1MS_CNT(PULSE_1MS_CNT),
            .MIN_PULSE_CNT(MIN_PULSE_CNT),
            .MAX_PULSE_CNT(MAX_PULSE_CNT),
            .TIMEOUT_CNT  (TIMEOUT_CNT)
        ) u_ch (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .tick_i  (tick),
            .pulse_i (servo_pulse_i[i]),
            .value_o (servo_control_value_o[VALUE_W*i +: VALUE_W]),
            .valid_o (servo_valid_o[i]),
            .sample_o(servo_sample_o[i])
        );
    end

endmodule
